fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage controller. Owns the PC, the instruction-memory request, next-PC selection and the IF/ID pipeline register. Consumes the controller's stall, branch, jump, JR and self-modifying-code (SMC/SMC2) decisions. Produces IFPC, IDPC and IDIR for the controller and the ID datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
CLK  in  1  pipeline clock; all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
IMADDR  out  32  fetch address; always equals IFPC.
IMREQ  out  1  fetch request; 0 in reset cycle, 1 in every other cycle.
IMDATA  in  32  fetched word; valid only when IMRDY=1.
IMRDY  in  1  IMDATA valid for the current IMADDR this cycle.
WPCIR  in  1  controller stall: hold PC and IF/ID.
BRANCH  in  1  controller redirect request (beq/bne taken, j, jal, jr).
JUMP  in  1  redirect is j/jal.
JR  in  1  redirect is jr.
JRADDR  in  32  forwarded rs value for jr.
SMC  in  1  store in EX targets IDPC; refetch ID instruction.
SMC2  in  1  store in EX targets IFPC; refetch IF instruction.
IFPC  out  32  current PC.
IDPC  out  32  PC of the instruction in IF/ID.
IDIR  out  32  instruction in IF/ID.
IDVALID  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (RST=1 at an edge): PC=RESET_PC; IDIR=NOP; IDPC=0; IDVALID=0; IMREQ=0; state=FETCH; PEND=0. Reset wins over every other input, including mid-DRAIN.
- IMADDR must be held stable while IMREQ=1 and IMRDY=0.
- Qualification: BRANCH, JUMP, JR and SMC are honoured only when IDVALID=1. SMC2 is honoured in any state.
- Target, where P4 = IDPC+4:
  - JR=1: JRADDR.
  - Else JUMP=1: {P4[31:28], IDIR[25:0], 2'b00}.
  - Else: P4 + (sext(IDIR[15:0])<<2).
  - All arithmetic is 32-bit modulo 2^32; PC+4 wraps at 32'hFFFF_FFFC to 0.
- State FETCH, IMRDY=1, first match applies:
  1. SMC: PC<=IDPC, IF/ID<=bubble. Overrides WPCIR.
  2. WPCIR: PC and IF/ID hold. BRANCH is ignored.
  3. BRANCH: PC<=target, IF/ID<=bubble (squash; no delay slot).
  4. SMC2: PC holds (refetch), IF/ID<=bubble.
  5. Otherwise: IDIR<=IMDATA, IDPC<=PC, IDVALID<=1, PC<=PC+4.
- State FETCH, IMRDY=0:
  - PC holds.
  - IF/ID holds if WPCIR=1 and SMC=0; otherwise IF/ID<=bubble.
  - SMC or (BRANCH and not WPCIR): PEND<=IDPC (SMC) or target; state<=DRAIN.
- State DRAIN:
  - PC held, so the outstanding request stays stable.
  - IF/ID<=bubble each cycle.
  - IMRDY=1: data discarded, PC<=PEND, state<=FETCH.
  - SMC2 in DRAIN is ignored, because the drained word is discarded anyway.
- Bubble: IDIR=NOP, IDVALID=0, IDPC holds its previous value.
- Latency: 1 cycle from IMRDY=1 to IDIR valid. A redirect costs 1 bubble (more if memory is slow).

Test Plan:
- Reset, then IMRDY=1 with words W0..W3 -> IFPC 0,4,8,C; IDIR W0..W2 one cycle behind; IDVALID=1 from cycle 2.
- IDPC=0x10, IDIR=beq off 0xFFFF, BRANCH=1 -> next IFPC=0x10, one bubble. Repeat with WPCIR=1 -> PC/IF/ID hold, no redirect.
- jal with IDPC=0x3000_0000, IDIR[25:0]=0x40 -> IFPC=0x3000_0100; jr with JRADDR=0x80 -> IFPC=0x80.
- SMC=1 with WPCIR=1, IDPC=0x20 -> IFPC=0x20, IDVALID=0, then 0x20 refetched. SMC2=1 at IFPC=0x24 -> IFPC stays 0x24 for one cycle, bubble inserted.
- IMRDY=0 for 3 cycles, then BRANCH to 0x100 in the first of them -> IMADDR stable, DRAIN entered, data discarded on IMRDY, then IFPC=0x100.
- RST asserted during DRAIN -> IFPC=RESET_PC, IDVALID=0, state FETCH, PEND discarded; PC at 0xFFFF_FFFC advances to 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: IF-stage bundle between the fetch stage, instruction memory and ID controller.
interface fetch_stage_if;
    logic [31:0] IMADDR;
    logic        IMREQ;
    logic [31:0] IMDATA;
    logic        IMRDY;
    logic        WPCIR;
    logic        BRANCH;
    logic        JUMP;
    logic        JR;
    logic [31:0] JRADDR;
    logic        SMC;
    logic        SMC2;
    logic [31:0] IFPC;
    logic [31:0] IDPC;
    logic [31:0] IDIR;
    logic        IDVALID;
    modport master (
        output IMADDR, IMREQ, IFPC, IDPC, IDIR, IDVALID,
        input  IMDATA, IMRDY, WPCIR, BRANCH, JUMP, JR, JRADDR, SMC, SMC2
    );
    modport slave (
        input  IMADDR, IMREQ, IFPC, IDPC, IDIR, IDVALID,
        output IMDATA, IMRDY, WPCIR, BRANCH, JUMP, JR, JRADDR, SMC, SMC2
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage - PC, imem request, next-PC select, IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input logic          CLK,
    input logic          RST,
    fetch_stage_if.master bus
);
    typedef enum logic {FETCH, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, idpc_q, idpc_d, idir_q, idir_d, pend_q, pend_d;
    logic        valid_q, valid_d;
    logic [31:0] p4, target;
    logic        smc, br, bubble;
    assign p4     = idpc_q + 32'd4;
    assign target = bus.JR ? bus.JRADDR :
                    bus.JUMP ? {p4[31:28], idir_q[25:0], 2'b00} :
                    p4 + {{14{idir_q[15]}}, idir_q[15:0], 2'b00};
    assign smc    = bus.SMC & valid_q;
    assign br     = bus.BRANCH & valid_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idpc_d  = idpc_q;
        idir_d  = idir_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        bubble  = 1'b0;
        if (state_q == DRAIN) begin
            bubble = 1'b1;
            if (bus.IMRDY) begin
                pc_d    = pend_q;
                state_d = FETCH;
            end
        end else if (bus.IMRDY) begin
            if (smc) begin
                pc_d   = idpc_q;
                bubble = 1'b1;
            end else if (!bus.WPCIR) begin
                if (br) begin
                    pc_d   = target;
                    bubble = 1'b1;
                end else if (bus.SMC2) begin
                    bubble = 1'b1;
                end else begin
                    idir_d  = bus.IMDATA;
                    idpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
        end else begin
            // memory busy: the outstanding request must stay put, so redirects wait in PEND
            bubble = smc | ~bus.WPCIR;
            if (smc | (br & ~bus.WPCIR)) begin
                pend_d  = smc ? idpc_q : target;
                state_d = DRAIN;
            end
        end
        if (bubble) begin
            idir_d  = NOP;
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            idpc_q  <= 32'h0;
            idir_q  <= NOP;
            valid_q <= 1'b0;
            pend_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idpc_q  <= idpc_d;
            idir_q  <= idir_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end
    assign bus.IMADDR  = pc_q;
    assign bus.IMREQ   = ~RST;
    assign bus.IFPC    = pc_q;
    assign bus.IDPC    = idpc_q;
    assign bus.IDIR    = idir_q;
    assign bus.IDVALID = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus hand sequences for reset-in-drain, wrap and SMC drain.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    fetch_stage_if bus();
    fetch_stage dut (.CLK(clk), .RST(rst), .bus(bus));
    always #5 clk = ~clk;

    localparam logic [6:0] R = 7'h40, WP = 7'h20, BR = 7'h10, JM = 7'h08, JRB = 7'h04, SM = 7'h02, S2 = 7'h01;
    typedef struct packed {
        logic [6:0]  ctl;
        logic [31:0] jraddr;
        logic [31:0] data;
        logic [31:0] ifpc;
        logic [31:0] idpc;
        logic [31:0] idir;
        logic        v;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [31:0] jraddr, input logic [31:0] data);
        bus.IMRDY  = ctl[6];
        bus.WPCIR  = ctl[5];
        bus.BRANCH = ctl[4];
        bus.JUMP   = ctl[3];
        bus.JR     = ctl[2];
        bus.SMC    = ctl[1];
        bus.SMC2   = ctl[0];
        bus.JRADDR = jraddr;
        bus.IMDATA = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input int idx, input logic [31:0] pc, input logic [31:0] idpc, input logic [31:0] idir, input logic v);
        chk("ifpc", idx, bus.IFPC, pc);
        chk("imaddr", idx, bus.IMADDR, pc);
        chk("idpc", idx, bus.IDPC, idpc);
        chk("idir", idx, bus.IDIR, idir);
        chk("idvalid", idx, {31'h0, bus.IDVALID}, {31'h0, v});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(7'h0, 32'h0, 32'h0);
        tbl.push_back('{R,          32'h0,         32'h1111_0000, 32'h4,         32'h0,         32'h1111_0000, 1'b1});
        tbl.push_back('{R,          32'h0,         32'h2222_0004, 32'h8,         32'h4,         32'h2222_0004, 1'b1});
        tbl.push_back('{R,          32'h0,         32'h3333_0008, 32'hC,         32'h8,         32'h3333_0008, 1'b1});
        tbl.push_back('{R,          32'h0,         32'h4444_000C, 32'h10,        32'hC,         32'h4444_000C, 1'b1});
        tbl.push_back('{R,          32'h0,         32'h1000_FFFF, 32'h14,        32'h10,        32'h1000_FFFF, 1'b1});
        tbl.push_back('{R|BR,       32'h0,         32'hAAAA_0014, 32'h10,        32'h10,        32'h0,         1'b0});
        tbl.push_back('{R|BR,       32'h0,         32'h1000_FFFF, 32'h14,        32'h10,        32'h1000_FFFF, 1'b1});
        tbl.push_back('{R|BR|WP,    32'h0,         32'hAAAA_0014, 32'h14,        32'h10,        32'h1000_FFFF, 1'b1});
        tbl.push_back('{R|BR|JRB,   32'h80,        32'hAAAA_0014, 32'h80,        32'h10,        32'h0,         1'b0});
        tbl.push_back('{R,          32'h0,         32'h3333_0080, 32'h84,        32'h80,        32'h3333_0080, 1'b1});
        tbl.push_back('{R|BR|JRB,   32'h3000_0000, 32'hAAAA_0084, 32'h3000_0000, 32'h80,        32'h0,         1'b0});
        tbl.push_back('{R,          32'h0,         32'h0C00_0040, 32'h3000_0004, 32'h3000_0000, 32'h0C00_0040, 1'b1});
        tbl.push_back('{R|BR|JM,    32'h0,         32'hAAAA_0004, 32'h3000_0100, 32'h3000_0000, 32'h0,         1'b0});
        tbl.push_back('{R,          32'h0,         32'h4444_0100, 32'h3000_0104, 32'h3000_0100, 32'h4444_0100, 1'b1});
        tbl.push_back('{R|BR|JRB,   32'h20,        32'hAAAA_0104, 32'h20,        32'h3000_0100, 32'h0,         1'b0});
        tbl.push_back('{R,          32'h0,         32'h5555_0020, 32'h24,        32'h20,        32'h5555_0020, 1'b1});
        tbl.push_back('{R|SM|WP,    32'h0,         32'hAAAA_0024, 32'h20,        32'h20,        32'h0,         1'b0});
        tbl.push_back('{R,          32'h0,         32'h5555_0020, 32'h24,        32'h20,        32'h5555_0020, 1'b1});
        tbl.push_back('{R|S2,       32'h0,         32'h1000_0036, 32'h24,        32'h20,        32'h0,         1'b0});
        tbl.push_back('{R,          32'h0,         32'h1000_0036, 32'h28,        32'h24,        32'h1000_0036, 1'b1});
        tbl.push_back('{BR,         32'h0,         32'hAAAA_0028, 32'h28,        32'h24,        32'h0,         1'b0});
        tbl.push_back('{7'h0,       32'h0,         32'hAAAA_0028, 32'h28,        32'h24,        32'h0,         1'b0});
        tbl.push_back('{BR|S2,      32'h0,         32'hAAAA_0028, 32'h28,        32'h24,        32'h0,         1'b0});
        tbl.push_back('{R,          32'h0,         32'hDEAD_BEEF, 32'h100,       32'h24,        32'h0,         1'b0});
        tbl.push_back('{R,          32'h0,         32'h7777_0100, 32'h104,       32'h100,       32'h7777_0100, 1'b1});
        tbl.push_back('{WP,         32'h0,         32'hAAAA_0104, 32'h104,       32'h100,       32'h7777_0100, 1'b1});
        tbl.push_back('{7'h0,       32'h0,         32'hAAAA_0104, 32'h104,       32'h100,       32'h0,         1'b0});

        tick();
        chk("rst_imreq", -1, {31'h0, bus.IMREQ}, 32'h0);
        chk_state(-1, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        chk("run_imreq", -1, {31'h0, bus.IMREQ}, 32'h1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ctl, tbl[i].jraddr, tbl[i].data);
            tick();
            chk_state(i, tbl[i].ifpc, tbl[i].idpc, tbl[i].idir, tbl[i].v);
            chk("imreq", i, {31'h0, bus.IMREQ}, 32'h1);
        end

        // reset while draining a pending jr: PEND must be forgotten
        drive(R, 32'h0, 32'h8888_0104);
        tick();
        chk_state(100, 32'h108, 32'h104, 32'h8888_0104, 1'b1);
        drive(BR|JRB, 32'h500, 32'h0);
        tick();
        chk_state(101, 32'h108, 32'h104, 32'h0, 1'b0);
        rst = 1'b1;
        drive(7'h0, 32'h0, 32'h0);
        tick();
        chk("drain_rst_imreq", 102, {31'h0, bus.IMREQ}, 32'h0);
        chk_state(102, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        drive(R, 32'h0, 32'h9999_0000);
        tick();
        chk_state(103, 32'h4, 32'h0, 32'h9999_0000, 1'b1);

        // PC wrap at the top of the address space
        drive(R|BR|JRB, 32'hFFFF_FFFC, 32'h0);
        tick();
        chk_state(104, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        drive(R, 32'h0, 32'hBBBB_FFFC);
        tick();
        chk_state(105, 32'h0, 32'hFFFF_FFFC, 32'hBBBB_FFFC, 1'b1);

        // SMC while memory is busy: drain, then refetch IDPC
        drive(SM, 32'h0, 32'h0);
        tick();
        chk_state(106, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        drive(R, 32'h0, 32'hCCCC_0000);
        tick();
        chk_state(107, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0);
        drive(R, 32'h0, 32'hBBBB_FFFC);
        tick();
        chk_state(108, 32'h0, 32'hFFFF_FFFC, 32'hBBBB_FFFC, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
